// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the I/D main-memory arbiter and the cache
// controllers that talk to it.
package mem_arb_pkg;

    localparam int ADDR_W    = 16;  // byte address width
    localparam int DATA_W    = 16;  // memory word width
    localparam int BURST_LEN = 4;   // words per line; power of two, >= 2

    localparam int IDX_W = $clog2(BURST_LEN);  // word index within a line
    localparam int CNT_W = IDX_W + 1;          // counters hold 0..BURST_LEN

    // Byte-offset bits within one line (words are 2 bytes wide).
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(BURST_LEN * 2 - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef enum logic {GNT_I, GNT_D} port_t;

    // Line-aligned base of any byte address.
    function automatic logic [ADDR_W-1:0] lineBase(input logic [ADDR_W-1:0] a);
        return a & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter. The master modport is
// the arbiter's view; slave is the view of the caches plus memory.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic [IDX_W-1:0]  i_widx;
    logic              i_done;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [IDX_W-1:0]  d_widx;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_stall;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              err;

    modport master (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
               mem_stall, mem_rvalid, mem_rdata,
        output i_rvalid, i_rdata, i_widx, i_done,
               d_widx, d_rvalid, d_rdata, d_done,
               mem_rd, mem_wr, mem_addr, mem_wdata, err
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
               mem_stall, mem_rvalid, mem_rdata,
        input  i_rvalid, i_rdata, i_widx, i_done,
               d_widx, d_rvalid, d_rdata, d_done,
               mem_rd, mem_wr, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/burst_counter.sv
// Word counter for one burst: synchronous clear, count enable, and a flag
// marking the final word of the line.
module burst_counter #(
    parameter int W    = 3,
    parameter int LAST = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    // Clear wins over enable so a new burst always starts from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + W'(1);
    end

    assign last = (cnt == W'(LAST));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported main memory between the I-cache and D-cache miss
// controllers, one whole-line burst per grant.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    state_t            state, nxt;
    port_t             grant, lastGrant, pick;
    logic              wrLat;
    logic [ADDR_W-1:0] base;

    logic [CNT_W-1:0]  issueCnt, respCnt;
    logic              issueLast, respLast;
    logic              issueEn, respOk, cntClr;

    // A return is only wanted while a read burst still has words outstanding.
    assign respOk  = bus.mem_rvalid && !wrLat && !respCnt[IDX_W] &&
                     (state == ISSUE || state == DRAIN);
    assign issueEn = (state == ISSUE) && !bus.mem_stall;
    assign cntClr  = (state == IDLE) || (state == DONE);

    burst_counter #(.W(CNT_W), .LAST(BURST_LEN - 1)) uIssueCnt (
        .clk(clk), .rst_n(rst_n), .clr(cntClr), .en(issueEn),
        .cnt(issueCnt), .last(issueLast)
    );

    burst_counter #(.W(CNT_W), .LAST(BURST_LEN - 1)) uRespCnt (
        .clk(clk), .rst_n(rst_n), .clr(cntClr), .en(respOk),
        .cnt(respCnt), .last(respLast)
    );

    // Arbitration: a lone request wins; on a tie the port not served last wins.
    always_comb begin
        pick = GNT_I;
        if (bus.i_req && bus.d_req) pick = (lastGrant == GNT_I) ? GNT_D : GNT_I;
        else if (bus.d_req)         pick = GNT_D;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state: a read that takes its last return while issuing skips DRAIN.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (bus.i_req || bus.d_req) nxt = ISSUE;
            ISSUE: if (issueEn && issueLast)
                       nxt = (wrLat || (respOk && respLast)) ? DONE : DRAIN;
            DRAIN: if (respOk && respLast) nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Grant, direction and line base are frozen for the whole burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= GNT_I;
            lastGrant <= GNT_I;
            wrLat     <= 1'b0;
            base      <= '0;
        end else if (state == IDLE && (bus.i_req || bus.d_req)) begin
            grant <= pick;
            wrLat <= (pick == GNT_D) && bus.d_wr;
            base  <= lineBase((pick == GNT_D) ? bus.d_addr : bus.i_addr);
        end else if (state == DONE) begin
            lastGrant <= grant;
        end
    end

    // Memory request side; a stalled word stays on the bus unchanged.
    always_comb begin
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state == ISSUE) begin
            bus.mem_rd   = !wrLat;
            bus.mem_wr   = wrLat;
            bus.mem_addr = base + ADDR_W'({issueCnt, 1'b0});
            if (wrLat) bus.mem_wdata = bus.d_wdata;
        end
    end

    // Response steering to the granted cache; unwanted returns flag err.
    always_comb begin
        bus.i_rvalid = respOk && (grant == GNT_I);
        bus.d_rvalid = respOk && (grant == GNT_D);
        bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
        bus.i_widx   = respCnt[IDX_W-1:0];
        bus.d_widx   = wrLat ? issueCnt[IDX_W-1:0] : respCnt[IDX_W-1:0];
        bus.i_done   = (state == DONE) && (grant == GNT_I);
        bus.d_done   = (state == DONE) && (grant == GNT_D);
        bus.err      = rst_n && bus.mem_rvalid && !respOk;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vector table for mem_arbiter against a latency-2 memory
// model, plus a hand-written tie/alternation sequence.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inj = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] rdataOf(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Memory: fixed two-cycle read latency, runs through DUT resets.
    logic        p1v = 1'b0, p2v = 1'b0;
    logic [15:0] p1a = '0, p2a = '0;
    always @(posedge clk) begin
        p1v <= bus.mem_rd && !bus.mem_stall;
        p1a <= bus.mem_addr;
        p2v <= p1v;
        p2a <= p1a;
    end
    assign bus.mem_rvalid = p2v | inj;
    assign bus.mem_rdata  = p2v ? rdataOf(p2a) : 16'hEEEE;
    assign bus.d_wdata    = 16'hD000 | 16'(bus.d_widx);

    typedef struct {
        logic rstN, iReq, dReq, dWr; logic [15:0] addr; logic stall, inj;
        logic rd, wr; logic [15:0] maddr, wdata; logic irv, drv;
        logic [1:0] iw, dw; logic idone, ddone, err; logic [15:0] rdata;
    } vec_t;

    vec_t tbl[$];
    int   nVec = 0, nBad = 0;

    function automatic vec_t V(
        input logic rstN, iReq, dReq, dWr, input logic [15:0] addr,
        input logic stall, inj, rd, wr, input logic [15:0] maddr, wdata,
        input logic irv, drv, input logic [1:0] iw, dw,
        input logic idone, ddone, err, input logic [15:0] rdata);
        vec_t v;
        v.rstN = rstN; v.iReq = iReq; v.dReq = dReq; v.dWr = dWr; v.addr = addr;
        v.stall = stall; v.inj = inj; v.rd = rd; v.wr = wr; v.maddr = maddr;
        v.wdata = wdata; v.irv = irv; v.drv = drv; v.iw = iw; v.dw = dw;
        v.idone = idone; v.ddone = ddone; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic checkRow(input int idx, input vec_t v);
        logic [74:0] got, exp;
        got = {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.i_rvalid,
               bus.d_rvalid, bus.i_widx, bus.d_widx, bus.i_done, bus.d_done,
               bus.err, bus.i_rdata, bus.d_rdata};
        exp = {v.rd, v.wr, v.maddr, v.wdata, v.irv, v.drv, v.iw, v.dw, v.idone,
               v.ddone, v.err, v.irv ? v.rdata : 16'h0, v.drv ? v.rdata : 16'h0};
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL vec %0d: got {rd,wr,addr,wdata,irv,drv,iw,dw,idone,ddone,err,irdata,drdata}=%h expected %h",
                     idx, got, exp);
        end
    endtask

    port_t expOrder[3] = '{GNT_D, GNT_I, GNT_D};
    port_t order[3];
    int    nDone;
    logic  reI, reD;

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_wr = 0;
        bus.d_addr = 0; bus.mem_stall = 0;

        //        rst iR dR dW addr      st inj rd wr maddr     wdata     irv drv iw dw idn ddn err rdata
        // reset
        tbl.push_back(V(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        // I fill at 0x0013
        tbl.push_back(V(1, 1, 0, 0, 16'h0013, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0013, 0, 0, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0013, 0, 0, 1, 0, 16'h0012, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0013, 0, 0, 1, 0, 16'h0014, 16'h0000, 1, 0, 0, 0, 0, 0, 0, rdataOf(16'h0010)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0013, 0, 0, 1, 0, 16'h0016, 16'h0000, 1, 0, 1, 1, 0, 0, 0, rdataOf(16'h0012)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0013, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 2, 2, 0, 0, 0, rdataOf(16'h0014)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0013, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 3, 3, 0, 0, 0, rdataOf(16'h0016)));
        tbl.push_back(V(1, 0, 0, 0, 16'h0013, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        // D write-back at 0x0A08, then an unexpected return in IDLE
        tbl.push_back(V(1, 0, 1, 1, 16'h0A08, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 1, 1, 16'h0A08, 0, 0, 0, 1, 16'h0A08, 16'hD000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 1, 1, 16'h0A08, 0, 0, 0, 1, 16'h0A0A, 16'hD001, 0, 0, 0, 1, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 1, 1, 16'h0A08, 0, 0, 0, 1, 16'h0A0C, 16'hD002, 0, 0, 0, 2, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 1, 1, 16'h0A08, 0, 0, 0, 1, 16'h0A0E, 16'hD003, 0, 0, 0, 3, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 0, 0, 16'h0A08, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 16'h0));
        tbl.push_back(V(1, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 16'h0));
        tbl.push_back(V(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        // I fill at 0x0020 with one stalled word
        tbl.push_back(V(1, 1, 0, 0, 16'h0020, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0020, 0, 0, 1, 0, 16'h0020, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0020, 1, 0, 1, 0, 16'h0022, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0020, 0, 0, 1, 0, 16'h0022, 16'h0000, 1, 0, 0, 0, 0, 0, 0, rdataOf(16'h0020)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0020, 0, 0, 1, 0, 16'h0024, 16'h0000, 0, 0, 1, 1, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0020, 0, 0, 1, 0, 16'h0026, 16'h0000, 1, 0, 1, 1, 0, 0, 0, rdataOf(16'h0022)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0020, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 2, 2, 0, 0, 0, rdataOf(16'h0024)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0020, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 3, 3, 0, 0, 0, rdataOf(16'h0026)));
        tbl.push_back(V(1, 0, 0, 0, 16'h0020, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0));
        // D fill at 0xFFFA (top line), then injected return in IDLE
        tbl.push_back(V(1, 0, 1, 0, 16'hFFFA, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 1, 0, 16'hFFFA, 0, 0, 1, 0, 16'hFFF8, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 1, 0, 16'hFFFA, 0, 0, 1, 0, 16'hFFFA, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 1, 0, 16'hFFFA, 0, 0, 1, 0, 16'hFFFC, 16'h0000, 0, 1, 0, 0, 0, 0, 0, rdataOf(16'hFFF8)));
        tbl.push_back(V(1, 0, 1, 0, 16'hFFFA, 0, 0, 1, 0, 16'hFFFE, 16'h0000, 0, 1, 1, 1, 0, 0, 0, rdataOf(16'hFFFA)));
        tbl.push_back(V(1, 0, 1, 0, 16'hFFFA, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 2, 2, 0, 0, 0, rdataOf(16'hFFFC)));
        tbl.push_back(V(1, 0, 1, 0, 16'hFFFA, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 3, 3, 0, 0, 0, rdataOf(16'hFFFE)));
        tbl.push_back(V(1, 0, 0, 0, 16'hFFFA, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 16'h0));
        tbl.push_back(V(1, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 16'h0));
        tbl.push_back(V(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        // reset in the middle of an I fill, stale return, then a clean fill
        tbl.push_back(V(1, 1, 0, 0, 16'h0040, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0040, 0, 0, 1, 0, 16'h0040, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0040, 0, 0, 1, 0, 16'h0042, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(0, 1, 0, 0, 16'h0040, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 0, 0, 16'h0040, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0050, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0050, 0, 0, 1, 0, 16'h0050, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0050, 0, 0, 1, 0, 16'h0052, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(V(1, 1, 0, 0, 16'h0050, 0, 0, 1, 0, 16'h0054, 16'h0000, 1, 0, 0, 0, 0, 0, 0, rdataOf(16'h0050)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0050, 0, 0, 1, 0, 16'h0056, 16'h0000, 1, 0, 1, 1, 0, 0, 0, rdataOf(16'h0052)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0050, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 2, 2, 0, 0, 0, rdataOf(16'h0054)));
        tbl.push_back(V(1, 1, 0, 0, 16'h0050, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 3, 3, 0, 0, 0, rdataOf(16'h0056)));
        tbl.push_back(V(1, 0, 0, 0, 16'h0050, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0));
        tbl.push_back(V(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0));

        repeat (2) @(posedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            rst_n = tbl[k].rstN;
            bus.i_req = tbl[k].iReq;  bus.i_addr = tbl[k].addr;
            bus.d_req = tbl[k].dReq;  bus.d_wr = tbl[k].dWr;
            bus.d_addr = tbl[k].addr; bus.mem_stall = tbl[k].stall;
            inj = tbl[k].inj;
            @(negedge clk);
            checkRow(k, tbl[k]);
        end

        // Tie sequence from reset: both requests held, each re-raised right
        // after its done, so every arbitration is a tie.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.i_addr = 16'h0100; bus.d_addr = 16'h0200; bus.d_wr = 1'b1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        nDone = 0; reI = 1'b0; reD = 1'b0;
        for (int c = 0; c < 80 && nDone < 3; c++) begin
            @(negedge clk);
            if (reI) begin bus.i_req = 1'b1; reI = 1'b0; end
            if (reD) begin bus.d_req = 1'b1; reD = 1'b0; end
            if (bus.i_done) begin order[nDone] = GNT_I; nDone++; bus.i_req = 1'b0; reI = 1'b1; end
            if (bus.d_done) begin order[nDone] = GNT_D; nDone++; bus.d_req = 1'b0; reD = 1'b1; end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            nVec++;
            if (j >= nDone) begin
                nBad++;
                $display("FAIL tie grant %0d: no done within cycle budget, expected %s", j, expOrder[j].name());
            end else if (order[j] != expOrder[j]) begin
                nBad++;
                $display("FAIL tie grant %0d: got %s expected %s", j, order[j].name(), expOrder[j].name());
            end
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported main memory between the instruction-cache and data-cache miss controllers.
- Each granted requester receives one whole-line burst: BURST_LEN word reads (line fill) or BURST_LEN word writes (write-back).
- Sits between fetch0/memory0 cache controllers and the banked main memory.
- Burst completion is the event behind the fetch/memory Done signals on a cache miss.

Parameters:
ADDR_W, 16, address width in bytes
DATA_W, 16, word width
BURST_LEN, 4, words per line burst; power of two, at least 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  I-cache line-fill request; held until i_done
i_addr  in  ADDR_W  I-cache miss address (any byte within the line)
i_rvalid  out  1  fill word valid for I-cache
i_rdata  out  DATA_W  fill word (copy of mem_rdata)
i_widx  out  log2(BURST_LEN)  index of the word in i_rvalid/i_rdata
i_done  out  1  one-cycle burst-complete pulse to I-cache
d_req  in  1  D-cache request; held until d_done
d_wr  in  1  1 = write-back burst, 0 = line fill; stable while d_req high
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  DATA_W  write word selected by d_widx (combinational from D-cache)
d_widx  out  log2(BURST_LEN)  word index: being issued (write) or being returned (read)
d_rvalid  out  1  fill word valid for D-cache
d_rdata  out  DATA_W  fill word
d_done  out  1  one-cycle burst-complete pulse to D-cache
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_stall  in  1  memory busy; request this cycle not accepted
mem_rvalid  in  1  read data return (fixed memory latency, in order)
mem_rdata  in  DATA_W  read data
err  out  1  one-cycle pulse on unexpected mem_rvalid

Behaviour:
- Reset: state IDLE, both counters 0, last_grant = I. All outputs are 0 during and after reset until the first grant.
- States:
  - IDLE: sample requests and arbitrate.
  - ISSUE: send BURST_LEN words.
  - DRAIN: reads only; wait for the remaining returns.
  - DONE: one cycle; assert the done pulse to the granted port.
- Arbitration happens in IDLE only.
  - Only one request high: grant it.
  - Both high: grant the port opposite last_grant, so D wins the first tie and ties alternate afterwards.
  - The grant is registered; ISSUE starts the next cycle.
  - The granted port, d_wr, and the aligned base address are latched for the whole burst.
- Base address = requester address with the low log2(BURST_LEN*2) bits cleared. Word k is at base + 2k, wrapping modulo 2^ADDR_W.
- ISSUE:
  - mem_rd = !wr_latched, mem_wr = wr_latched, mem_addr = base + 2*issue_cnt, mem_wdata = d_wdata.
  - issue_cnt increments only when mem_stall = 0. A stalled word is re-presented unchanged.
  - When the last word is accepted: write → DONE; read → DRAIN, or DONE if the final response arrives in that same cycle.
- Responses:
  - Each mem_rvalid during ISSUE/DRAIN of a read increments resp_cnt.
  - It pulses <port>_rvalid with rdata = mem_rdata and widx = resp_cnt.
  - DRAIN → DONE in the cycle after the response with resp_cnt = BURST_LEN-1.
- d_widx equals issue_cnt during writes and resp_cnt during reads. i_widx equals resp_cnt.
- DONE:
  - <port>_done = 1 for exactly one cycle; last_grant ← the granted port; → IDLE.
  - Requests are not sampled in DONE. The requester drops req in its done cycle.
- mem_rvalid in IDLE, DONE, a write burst, or after BURST_LEN responses: the word is dropped and err pulses. No state change.
- Reset mid-burst: immediate return to IDLE with counters cleared. Stale returns from memory afterwards are dropped (err pulses).
- Counters are log2(BURST_LEN)+1 bits wide; they never wrap within a burst.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ISSUE, DRAIN, DONE}
  - port enum {GNT_I, GNT_D}
  - BURST_LEN, and the offset-mask constant shared with the cache controllers
- Sub-module burst_counter: a counter with clear, an enable, and a last flag, instantiated twice (issue and response).
- Arbitration and output steering stay in the top module.

Test Plan:
- Memory latency 2 for all cases below.
- I fill: i_req=1, i_addr=0x0013 at cycle 0 → mem_rd with mem_addr 0x0010/0x0012/0x0014/0x0016 in cycles 1–4; i_rvalid in cycles 3–6 with i_widx 0–3; i_done only in cycle 7.
- D write-back: d_req=1, d_wr=1, d_addr=0x0A08 → mem_wr with addresses 0x0A08–0x0A0E in cycles 1–4; mem_wdata tracks d_wdata[d_widx]; d_done in cycle 5; no rvalid pulses.
- Tie and alternation: i_req and d_req both high, held through → D granted first; after d_done, I granted; after i_done, D granted.
- Stall: mem_stall=1 in cycle 2 of an I fill → address 0x0012 presented in cycles 2 and 3; remaining words shift by one; i_done in cycle 8; exactly 4 rvalids.
- Wrap and error: d_addr=0xFFFA read → addresses 0xFFF8/FA/FC/FE. An injected mem_rvalid in IDLE → err pulses for one cycle; no d_rvalid.
- Reset mid-burst: rst_n low in cycle 3 → all outputs 0 immediately; returns arriving after release raise err; a new i_req is served normally.
